// File: rtl/iob_timer_mc.sv
// Multi-channel timer: N_CH auto-reload counters on a shared prescaler, with compare
// match, one-shot mode, maskable interrupts and an atomic shadow snapshot for reads.
module iob_timer_mc #(
  parameter  int unsigned N_CH    = 4,
  parameter  int unsigned CNT_W   = 32,
  parameter  int unsigned PRESC_W = 16,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk_i,
  input  logic               arst_n_i,
  input  logic               cke_i,
  input  logic               wen_i,
  input  logic [1:0]         waddr_i,
  input  logic [CH_W-1:0]    wch_i,
  input  logic [CNT_W-1:0]   wdata_i,
  input  logic               sample_i,
  input  logic [CH_W-1:0]    rch_i,
  output logic [CNT_W-1:0]   rdata_o,
  output logic [N_CH-1:0]    tick_o,
  output logic [N_CH-1:0]    match_o,
  input  logic [N_CH-1:0]    irq_ack_i,
  output logic               irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             r_state     [N_CH];
  state_e             w_state_nxt [N_CH];
  logic [CNT_W-1:0]   r_cnt       [N_CH];
  logic [CNT_W-1:0]   r_shadow    [N_CH];
  logic [CNT_W-1:0]   r_period    [N_CH];
  logic [CNT_W-1:0]   r_cmp       [N_CH];
  logic [N_CH-1:0]    r_oneshot;
  logic [N_CH-1:0]    r_ie_wrap;
  logic [N_CH-1:0]    r_ie_match;
  logic [N_CH-1:0]    r_wrap_pend;
  logic [N_CH-1:0]    r_match_pend;
  logic [N_CH-1:0]    r_tick;
  logic [N_CH-1:0]    r_match;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_presc_cnt;

  logic               w_step;
  logic               w_presc_wr;
  logic [N_CH-1:0]    w_ctrl_wr;
  logic [N_CH-1:0]    w_per_wr;
  logic [N_CH-1:0]    w_cmp_wr;
  logic [N_CH-1:0]    w_clr;
  logic [N_CH-1:0]    w_en_wr;
  logic [N_CH-1:0]    w_dis_wr;
  logic [N_CH-1:0]    w_go;
  logic [N_CH-1:0]    w_reload;
  logic [N_CH-1:0]    w_hit;
  logic [N_CH-1:0]    w_os_done;
  logic [N_CH-1:0]    w_restart;

  // Per-channel write decode and count/reload/match events for this cycle
  always_comb begin
    w_step     = cke_i & (r_presc_cnt == r_presc);
    w_presc_wr = wen_i & (waddr_i == 2'd3);
    for (int i = 0; i < int'(N_CH); i++) begin
      w_ctrl_wr[i] = wen_i & (waddr_i == 2'd0) & (wch_i == CH_W'(i));
      w_per_wr[i]  = wen_i & (waddr_i == 2'd1) & (wch_i == CH_W'(i));
      w_cmp_wr[i]  = wen_i & (waddr_i == 2'd2) & (wch_i == CH_W'(i));
      w_clr[i]     = w_ctrl_wr[i] & wdata_i[4];
      w_en_wr[i]   = w_ctrl_wr[i] & wdata_i[0];
      w_dis_wr[i]  = w_ctrl_wr[i] & ~wdata_i[0];
      // A disabling write or CLR suppresses the step in the same cycle
      w_go[i]      = (r_state[i] == ST_RUN) & w_step & ~w_clr[i] & ~w_dis_wr[i];
      w_reload[i]  = w_go[i] & (r_cnt[i] >= r_period[i]);
      w_hit[i]     = w_go[i] & (w_reload[i] ? (r_cmp[i] == '0)
                                            : ((r_cnt[i] + CNT_W'(1)) == r_cmp[i]));
      w_os_done[i] = w_reload[i] & r_oneshot[i];
      w_restart[i] = (r_state[i] == ST_DONE) & w_en_wr[i];
    end
  end

  // Channel FSM next state; RUN doubles as the EN bit
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      w_state_nxt[i] = r_state[i];
      unique case (r_state[i])
        ST_IDLE: if (w_en_wr[i]) w_state_nxt[i] = ST_RUN;
        ST_RUN: begin
          if (w_os_done[i])     w_state_nxt[i] = ST_DONE;
          else if (w_dis_wr[i]) w_state_nxt[i] = ST_IDLE;
        end
        ST_DONE: begin
          if (w_en_wr[i])    w_state_nxt[i] = ST_RUN;
          else if (w_clr[i]) w_state_nxt[i] = ST_IDLE;
        end
        default: w_state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < int'(N_CH); i++) r_state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < int'(N_CH); i++) r_state[i] <= w_state_nxt[i];
    end
  end

  // Prescaler, counters, shadows, configuration and pending flags
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_presc      <= '0;
      r_presc_cnt  <= '0;
      r_oneshot    <= '0;
      r_ie_wrap    <= '0;
      r_ie_match   <= '0;
      r_wrap_pend  <= '0;
      r_match_pend <= '0;
      r_tick       <= '0;
      r_match      <= '0;
      for (int i = 0; i < int'(N_CH); i++) begin
        r_cnt[i]    <= '0;
        r_shadow[i] <= '0;
        r_period[i] <= '0;
        r_cmp[i]    <= '0;
      end
    end else begin
      if (w_presc_wr) begin
        r_presc     <= wdata_i[PRESC_W-1:0];
        r_presc_cnt <= '0;
      end else if (cke_i) begin
        r_presc_cnt <= w_step ? '0 : r_presc_cnt + PRESC_W'(1);
      end
      for (int i = 0; i < int'(N_CH); i++) begin
        if (sample_i) r_shadow[i] <= r_cnt[i];
        if (w_clr[i] || w_restart[i]) r_cnt[i] <= '0;
        else if (w_go[i])             r_cnt[i] <= w_reload[i] ? '0 : r_cnt[i] + CNT_W'(1);
        if (w_per_wr[i]) r_period[i] <= wdata_i;
        if (w_cmp_wr[i]) r_cmp[i]    <= wdata_i;
        if (w_ctrl_wr[i]) begin
          r_oneshot[i]  <= wdata_i[1];
          r_ie_wrap[i]  <= wdata_i[2];
          r_ie_match[i] <= wdata_i[3];
        end
        r_tick[i]  <= w_reload[i];
        r_match[i] <= w_hit[i];
        // Setting beats a coincident acknowledge
        if (w_reload[i] && r_ie_wrap[i])     r_wrap_pend[i] <= 1'b1;
        else if (w_clr[i] || irq_ack_i[i])   r_wrap_pend[i] <= 1'b0;
        if (w_hit[i] && r_ie_match[i])       r_match_pend[i] <= 1'b1;
        else if (w_clr[i] || irq_ack_i[i])   r_match_pend[i] <= 1'b0;
      end
    end
  end

  assign rdata_o = r_shadow[rch_i];
  assign tick_o  = r_tick;
  assign match_o = r_match;
  assign irq_o   = |(r_wrap_pend | r_match_pend);

endmodule
